// File: rtl/credit_based_policer.sv
// Ingress credit-based policer: meters a byte-wide AXI4-Stream with a signed credit model and
// decides pass/drop once per frame at frame start.
module credit_based_policer #(
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     policer_enable,
  input  logic [31:0]              idle_slope,
  input  logic [31:0]              send_slope,
  input  logic [31:0]              max_credit,
  input  logic [31:0]              min_credit,
  output logic [31:0]              credit,
  output logic [COUNTER_WIDTH-1:0] pass_frame_count,
  output logic [COUNTER_WIDTH-1:0] drop_frame_count,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser
);

  typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              credit_q, credit_d;
  logic [COUNTER_WIDTH-1:0] pass_cnt_q, drop_cnt_q;
  logic                     pass_inc, drop_inc;

  logic                     charged;
  logic [31:0]              charge_sum, idle_sum;
  logic                     underflow, overflow;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: decision taken once, from the credit registered in the idle cycle
  always_comb begin
    state_d  = state_q;
    pass_inc = 1'b0;
    drop_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid) begin
          state_d = (!credit_q[31] || !policer_enable) ? StPass : StDrop;
        end
      end
      StPass: begin
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d  = StIdle;
          pass_inc = 1'b1;
        end
      end
      StDrop: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d  = StIdle;
          drop_inc = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; handshakes are forced low while reset is held
  always_comb begin
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state_q)
      StIdle: begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
      end
      StPass: begin
        m_axis_tvalid = s_axis_tvalid & ~rst;
        s_axis_tready = m_axis_tready & ~rst;
      end
      StDrop: begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = ~rst;
      end
      default: begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
      end
    endcase
  end

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tlast = s_axis_tlast;
  assign m_axis_tuser = s_axis_tuser;

  // Credit arithmetic in 32-bit two's complement with explicit wrap detection
  assign charged    = (state_q == StPass) && s_axis_tvalid && m_axis_tready;
  assign charge_sum = credit_q + send_slope;
  assign idle_sum   = credit_q + idle_slope;
  assign underflow  = credit_q[31] & ~charge_sum[31];
  assign overflow   = ~credit_q[31] & idle_sum[31];

  always_comb begin
    credit_d = credit_q;
    if (!policer_enable) begin
      credit_d = '0;
    end else if (charged) begin
      if (underflow || ($signed(charge_sum) < $signed(min_credit))) begin
        credit_d = min_credit;
      end else begin
        credit_d = charge_sum;
      end
    end else begin
      if (overflow || ($signed(idle_sum) > $signed(max_credit))) begin
        credit_d = max_credit;
      end else begin
        credit_d = idle_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q   <= '0;
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      credit_q <= credit_d;
      if (pass_inc) begin
        pass_cnt_q <= pass_cnt_q + 1'b1;
      end
      if (drop_inc) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign credit           = credit_q;
  assign pass_frame_count = pass_cnt_q;
  assign drop_frame_count = drop_cnt_q;

endmodule
